ttt_turn_sequencer: RTL and testbench

- Game-flow controller for the tic-tac-toe datapath. Owns the X (human) and O (computer) board registers and accepts human moves over a valid/ready handshake.
- Drives the board into the external strategy logic and its 4-way priority selector. Waits for that logic to settle, then samples and applies the one-hot computer move.
- Detects win, draw and fault conditions, and reports the game result.

---
 rtl/ttt_turn_sequencer.sv | 171 +++++++++++++++++
 tb/tb_ttt_turn_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe game-flow controller: owns both boards, takes human moves, applies the
// settled computer move and reports win/draw/fault. Optional human move timeout: TTT_MOVE_TIMEOUT_EN.
module ttt_turn_sequencer #(
   parameter int SETTLE_CYCLES  = 1,
   parameter int HUMAN_FIRST    = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       human_valid,
   input  logic [8:0] human_move,
   output logic       human_ready,
   input  logic [8:0] comp_move,
   output logic [8:0] x_board,
   output logic [8:0] o_board,
   output logic       busy,
   output logic       game_over,
   output logic [1:0] result,
   output logic       illegal,
   output logic       comp_fault,
   output logic [3:0] turn_count
);

   typedef enum logic [2:0] {IDLE, WAIT_H, CHECK_H, SETTLE, CHECK_C, DONE} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [1:0] RES_NONE = 2'b00, RES_HUMAN = 2'b01, RES_COMP = 2'b10, RES_DRAW = 2'b11;

   state_t     state, state_n;
   logic [8:0] x_n, o_n;
   logic [3:0] tc_n, cnt, cnt_n;
   logic [1:0] res_n;
   logic       fault_n, illegal_n;
   logic [8:0] occ;
   logic       legal_h, legal_c;

`ifdef TTT_MOVE_TIMEOUT_EN
   logic [15:0] tcnt, tcnt_n;
`endif

   function automatic logic onehot9(input logic [8:0] m);
      return (m != 9'd0) && ((m & (m - 9'd1)) == 9'd0);
   endfunction

   function automatic logic has_line(input logic [8:0] b);
      return (&b[2:0]) || (&b[5:3]) || (&b[8:6]) ||
             (b[0] & b[3] & b[6]) || (b[1] & b[4] & b[7]) || (b[2] & b[5] & b[8]) ||
             (b[0] & b[4] & b[8]) || (b[2] & b[4] & b[6]);
   endfunction

   assign occ     = x_board | o_board;
   assign legal_h = onehot9(human_move) && ((human_move & occ) == 9'd0);
   assign legal_c = onehot9(comp_move) && ((comp_move & occ) == 9'd0);

   assign human_ready = (state == WAIT_H);
   assign busy        = (state != IDLE) && (state != DONE);
   assign game_over   = (state == DONE);

   always_comb begin
      state_n   = state;
      x_n       = x_board;
      o_n       = o_board;
      tc_n      = turn_count;
      res_n     = result;
      fault_n   = comp_fault;
      illegal_n = 1'b0;
      cnt_n     = cnt;
`ifdef TTT_MOVE_TIMEOUT_EN
      tcnt_n    = '0;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               x_n     = '0;
               o_n     = '0;
               tc_n    = '0;
               res_n   = RES_NONE;
               fault_n = 1'b0;
               cnt_n   = SETTLE_LOAD;
               state_n = (HUMAN_FIRST != 0) ? WAIT_H : SETTLE;
            end
         end
         WAIT_H: begin
            if (human_valid && legal_h) begin
               x_n     = x_board | human_move;
               tc_n    = turn_count + 4'd1;
               state_n = CHECK_H;
            end else begin
               illegal_n = human_valid;
`ifdef TTT_MOVE_TIMEOUT_EN
               // Counter is held at zero outside WAIT_H, so entry always starts fresh.
               if (tcnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  res_n   = RES_COMP;
                  state_n = DONE;
               end else begin
                  tcnt_n = tcnt + 16'd1;
               end
`endif
            end
         end
         CHECK_H: begin
            if (has_line(x_board)) begin
               res_n   = RES_HUMAN;
               state_n = DONE;
            end else if (turn_count == 4'd9) begin
               res_n   = RES_DRAW;
               state_n = DONE;
            end else begin
               cnt_n   = SETTLE_LOAD;
               state_n = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else if (legal_c) begin
               o_n     = o_board | comp_move;
               tc_n    = turn_count + 4'd1;
               state_n = CHECK_C;
            end else begin
               fault_n = 1'b1;
               res_n   = RES_DRAW;
               state_n = DONE;
            end
         end
         CHECK_C: begin
            if (has_line(o_board)) begin
               res_n   = RES_COMP;
               state_n = DONE;
            end else if (turn_count == 4'd9) begin
               res_n   = RES_DRAW;
               state_n = DONE;
            end else begin
               state_n = WAIT_H;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         x_board    <= '0;
         o_board    <= '0;
         turn_count <= '0;
         result     <= RES_NONE;
         comp_fault <= 1'b0;
         illegal    <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_n;
         x_board    <= x_n;
         o_board    <= o_n;
         turn_count <= tc_n;
         result     <= res_n;
         comp_fault <= fault_n;
         illegal    <= illegal_n;
         cnt        <= cnt_n;
      end
   end

`ifdef TTT_MOVE_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tcnt <= '0;
      else       tcnt <= tcnt_n;
   end
`endif

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Directed bench for ttt_turn_sequencer (SETTLE_CYCLES=1, human first); inputs driven and
// outputs sampled on the falling edge.
module tb_ttt_turn_sequencer;

`ifdef TTT_MOVE_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       human_valid = 1'b0;
   logic [8:0] human_move = '0;
   logic [8:0] comp_move = '0;
   logic       human_ready, busy, game_over, illegal, comp_fault;
   logic [8:0] x_board, o_board;
   logic [1:0] result;
   logic [3:0] turn_count;

   int tests = 0;
   int fails = 0;

   ttt_turn_sequencer #(.SETTLE_CYCLES(1), .HUMAN_FIRST(1), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start),
      .human_valid(human_valid), .human_move(human_move), .human_ready(human_ready),
      .comp_move(comp_move), .x_board(x_board), .o_board(o_board),
      .busy(busy), .game_over(game_over), .result(result), .illegal(illegal),
      .comp_fault(comp_fault), .turn_count(turn_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic hmove(input logic [8:0] m);
      human_valid = 1'b1;
      human_move  = m;
      cyc();
      human_valid = 1'b0;
      human_move  = '0;
   endtask

   // Human move then computer reply, ending back in WAIT_H.
   task automatic turn(input logic [8:0] h, input logic [8:0] c);
      comp_move = c;
      hmove(h);
      repeat (3) cyc();
   endtask

   initial begin
      // reset state
      repeat (2) cyc();
      chk("rst_x", 16'(x_board), 16'h0);
      chk("rst_o", 16'(o_board), 16'h0);
      chk("rst_tc", 16'(turn_count), 16'h0);
      chk("rst_flags", {11'd0, busy, game_over, human_ready, illegal, comp_fault}, 16'h0);
      chk("rst_res", 16'(result), 16'h0);
      reset = 1'b0;
      cyc();

      do_start();
      chk("start_ready", 16'(human_ready), 16'h1);
      chk("start_busy", 16'(busy), 16'h1);
      chk("start_boards", {7'd0, x_board | o_board}, 16'h0);
      chk("start_res", 16'(result), 16'h0);

      // centre move, computer takes corner 0
      comp_move = 9'h001;
      hmove(9'h010);
      chk("c1_x", 16'(x_board), 16'h010);
      chk("c1_o", 16'(o_board), 16'h000);
      chk("c1_tc", 16'(turn_count), 16'h1);
      cyc();
      chk("c2_o", 16'(o_board), 16'h000);
      cyc();
      chk("c3_o", 16'(o_board), 16'h001);
      chk("c3_tc", 16'(turn_count), 16'h2);
      chk("c3_ready", 16'(human_ready), 16'h0);
      cyc();
      chk("c4_ready", 16'(human_ready), 16'h1);

      // illegal moves: two bits, occupied cell, empty request
      hmove(9'h011);
      chk("ill2_pulse", 16'(illegal), 16'h1);
      chk("ill2_x", 16'(x_board), 16'h010);
      chk("ill2_tc", 16'(turn_count), 16'h2);
      cyc();
      chk("ill2_clear", 16'(illegal), 16'h0);
      hmove(9'h001);
      chk("illocc_pulse", 16'(illegal), 16'h1);
      chk("illocc_o", 16'(o_board), 16'h001);
      chk("illocc_tc", 16'(turn_count), 16'h2);
      cyc();
      chk("illocc_clear", 16'(illegal), 16'h0);
      hmove(9'h000);
      chk("ill0_pulse", 16'(illegal), 16'h1);
      chk("ill0_x", 16'(x_board), 16'h010);
      cyc();
      chk("ill0_clear", 16'(illegal), 16'h0);
      chk("ill_ready", 16'(human_ready), 16'h1);

      // start mid-game is ignored
      do_start();
      chk("start_ign_x", 16'(x_board), 16'h010);

      // human wins on top row
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      do_start();
      turn(9'h001, 9'h008);
      turn(9'h002, 9'h010);
      hmove(9'h004);
      cyc();
      chk("win_over", 16'(game_over), 16'h1);
      chk("win_res", 16'(result), 16'h1);
      chk("win_o", 16'(o_board), 16'h018);
      chk("win_x", 16'(x_board), 16'h007);
      chk("win_tc", 16'(turn_count), 16'h5);
      chk("win_busy_rdy", {14'd0, busy, human_ready}, 16'h0);
      hmove(9'h100);
      chk("done_ign_x", 16'(x_board), 16'h007);
      chk("done_ign_ill", 16'(illegal), 16'h0);

      // full-board draw, human places the ninth mark
      do_start();
      chk("restart_clear", {7'd0, x_board | o_board}, 16'h0);
      turn(9'h001, 9'h002);
      turn(9'h004, 9'h010);
      turn(9'h008, 9'h020);
      turn(9'h080, 9'h040);
      hmove(9'h100);
      cyc();
      chk("draw_over", 16'(game_over), 16'h1);
      chk("draw_res", 16'(result), 16'h3);
      chk("draw_tc", 16'(turn_count), 16'h9);
      chk("draw_x", 16'(x_board), 16'h18D);
      chk("draw_o", 16'(o_board), 16'h072);
      chk("draw_fault", 16'(comp_fault), 16'h0);

      // computer presents no move
      do_start();
      comp_move = 9'h000;
      hmove(9'h010);
      repeat (2) cyc();
      chk("flt_fault", 16'(comp_fault), 16'h1);
      chk("flt_res", 16'(result), 16'h3);
      chk("flt_over", 16'(game_over), 16'h1);
      chk("flt_o", 16'(o_board), 16'h000);
      chk("flt_tc", 16'(turn_count), 16'h1);
      do_start();
      chk("flt_cleared", 16'(comp_fault), 16'h0);
      chk("flt_res_cleared", 16'(result), 16'h0);

      // asynchronous reset while in SETTLE
      comp_move = 9'h001;
      hmove(9'h010);
      cyc();
      chk("pre_rst_busy", 16'(busy), 16'h1);
      #2 reset = 1'b1;
      #1;
      chk("arst_x", 16'(x_board), 16'h0);
      chk("arst_tc", 16'(turn_count), 16'h0);
      chk("arst_flags", {14'd0, busy, human_ready}, 16'h0);
      cyc();
      reset = 1'b0;
      cyc();
      chk("arst_idle_o", 16'(o_board), 16'h0);

`ifdef TTT_MOVE_TIMEOUT_EN
      // idle human forfeits four cycles after entering WAIT_H
      do_start();
      repeat (3) cyc();
      chk("to_not_yet", 16'(game_over), 16'h0);
      cyc();
      chk("to_over", 16'(game_over), 16'h1);
      chk("to_res", 16'(result), 16'h2);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
